float_cmp_stream: RTL and testbench
===================================

Name: float_cmp_stream

Overview:
- Parametrised, pipelined successor to the team's combinational 13-bit float greater-than comparator.
- Accepts a stream of operand pairs (sign | exponent | fraction, sign-magnitude) on a valid/ready handshake.
- Produces a mode-selected compare flag and the larger operand of each pair.
- Tracks a running maximum across the stream; sits between the sample front-end and the peak-detect/threshold logic.

Parameters:
- EXP_W, 4, exponent field width in bits.
- FRAC_W, 8, fraction field width in bits.
- W (derived, localparam), 1+EXP_W+FRAC_W, operand width; 13 at defaults.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept a pair this cycle.
- a  input  W  operand A: [W-1] sign, [W-2:FRAC_W] exponent, [FRAC_W-1:0] fraction.
- b  input  W  operand B, same format.
- mode  input  2  00 GT, 01 LT, 10 EQ, 11 GE (A op B); captured with the pair.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- result  output  1  compare outcome for the selected mode.
- max_out  output  W  larger of A and B; A on ties.
- clr  input  1  synchronous clear of the running maximum.
- run_max  output  W  running maximum of accepted max_out values.
- run_max_valid  output  1  run_max holds at least one sample.

Behaviour:
- Reset (rst_n low, asynchronous): all pipeline valids 0; out_valid, result, max_out, run_max, run_max_valid = 0; in_ready = 1 one cycle after release.
- Ordering key per operand:
  - magnitude = {exponent, fraction}.
  - Canonical zero: magnitude 0 forces sign 0, so +0 == -0 (new behaviour; the old block ordered -0 < +0).
  - Key = {1, mag} if sign 0; {0, ~mag} if sign 1. Compare keys as unsigned.
- Pipeline, 2 stages:
  - S1 registers keys, raw operands and mode.
  - S2 registers result and max_out.
  - Latency exactly 2 cycles from in_valid&in_ready to out_valid with no stall.
- Flow control:
  - s2_free = !out_valid | out_ready; s1_free = !s1_valid | s2_free; in_ready = s1_free.
  - Full throughput, 1 pair/cycle, while out_ready stays high.
  - Stall: out_valid high and out_ready low holds result and max_out stable; S1 holds if occupied; in_ready drops only when both stages are full.
  - No data loss or duplication under any valid/ready pattern.
- Running max:
  - On each output handshake (out_valid & out_ready), load max_out into run_max if !run_max_valid or key(max_out) > key(run_max); set run_max_valid = 1.
  - clr alone: run_max_valid = 0, run_max = 0 next cycle.
  - clr and handshake in the same cycle: clear is applied first, so run_max = that max_out and run_max_valid = 1.
- Reset mid-stream: in-flight pairs are discarded; no output handshake follows reset release until new input arrives.

Optional Feature:
- Macro FLOAT_CMP_NAN_EN.
- Defined:
  - Exponent all-ones with non-zero fraction is NaN.
  - Any NaN operand gives result = 0 for every mode, including EQ.
  - max_out is the non-NaN operand; A if both are NaN.
  - A NaN never updates run_max.
  - Adds output port unordered (1 bit, registered with result, reset 0), high when either operand is NaN.
- Undefined: all encodings are ordinary numbers; no unordered port.

Test Plan:
- Basic compare, defaults: a=0x0380 (+, exp3, frac 0x80), b=0x0280, mode GT, out_ready=1 → out_valid exactly 2 cycles later; result=1, max_out=0x0380.
- Negatives: a=0x1380, b=0x1280, mode LT → result=1, max_out=0x1280. Same pair with mode GE → result=0.
- Signed zero: a=0x1000, b=0x0000, mode EQ → result=1, max_out=0x1000. Same pair with mode GT → result=0.
- Backpressure: 4 back-to-back pairs, out_ready held low 5 cycles then high → in_ready drops after 2 accepts; all 4 results appear in order, unchanged while stalled.
- Running max: accept max_outs 0x0280, 0x0380, 0x1500; then clr coincident with a handshake of max_out 0x0100 → run_max 0x0280 → 0x0380 → 0x0380, then 0x0100 with run_max_valid=1.
- NaN (FLOAT_CMP_NAN_EN defined): a=0x0F01, b=0x0100, each mode → result=0, unordered=1, max_out=0x0100, run_max unchanged by the NaN.

Source files
------------

// File: rtl/float_cmp_stream.sv
// Two-stage streaming float compare with a mode-selected flag, pairwise max and running max.
// Define FLOAT_CMP_NAN_EN to treat exp all-ones / frac non-zero as NaN and add the unordered port.
module float_cmp_stream #(
    parameter int EXP_W  = 4,
    parameter int FRAC_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+FRAC_W:0]   a,
    input  logic [EXP_W+FRAC_W:0]   b,
    input  logic [1:0]              mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    result,
    output logic [EXP_W+FRAC_W:0]   max_out,
`ifdef FLOAT_CMP_NAN_EN
    output logic                    unordered,
`endif
    input  logic                    clr,
    output logic [EXP_W+FRAC_W:0]   run_max,
    output logic                    run_max_valid
);

    localparam int W     = 1 + EXP_W + FRAC_W;
    localparam int MAG_W = EXP_W + FRAC_W;

    localparam logic [1:0] MODE_GT = 2'b00;
    localparam logic [1:0] MODE_LT = 2'b01;
    localparam logic [1:0] MODE_EQ = 2'b10;
    localparam logic [1:0] MODE_GE = 2'b11;

    // Monotonic unsigned key; a zero magnitude is always treated as positive so +0 == -0.
    function automatic logic [W-1:0] order_key(input logic [W-1:0] x);
        logic [MAG_W-1:0] mag;
        logic             neg;
        mag = x[MAG_W-1:0];
        neg = x[W-1] && (mag != '0);
        return neg ? {1'b0, ~mag} : {1'b1, mag};
    endfunction

    function automatic logic mode_select(input logic [1:0] m, input logic gt,
                                         input logic lt, input logic eq);
        logic r;
        case (m)
            MODE_GT: r = gt;
            MODE_LT: r = lt;
            MODE_EQ: r = eq;
            MODE_GE: r = gt | eq;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

`ifdef FLOAT_CMP_NAN_EN
    function automatic logic is_nan(input logic [W-1:0] x);
        return (&x[MAG_W-1:FRAC_W]) && (|x[FRAC_W-1:0]);
    endfunction
`endif

    logic           s1_free;
    logic           s2_free;
    logic           in_fire;
    logic           out_fire;

    logic           vld_p1_q, vld_p1_d;
    logic [W-1:0]   key_a_p1_q, key_b_p1_q;
    logic [W-1:0]   a_p1_q, b_p1_q;
    logic [1:0]     mode_p1_q;
`ifdef FLOAT_CMP_NAN_EN
    logic           nan_a_p1_q, nan_b_p1_q;
    logic           unord_p2_q, unord_p2_d;
`endif

    logic           vld_p2_q, vld_p2_d;
    logic           result_p2_q, result_p2_d;
    logic [W-1:0]   max_p2_q, max_p2_d;

    logic           cmp_result;
    logic [W-1:0]   cmp_max;
    logic           cmp_unord;

    logic [W-1:0]   run_max_q, run_max_d;
    logic           run_vld_q, run_vld_d;
    logic [W-1:0]   base_max;
    logic           base_vld;
    logic           max_ok;

    assign s2_free  = !vld_p2_q || out_ready;
    assign s1_free  = !vld_p1_q || s2_free;
    assign in_ready = s1_free;
    assign in_fire  = in_valid && s1_free;
    assign out_fire = vld_p2_q && out_ready;

    // ---- Stage 1: capture keys, raw operands and mode ----
    always_comb begin
        vld_p1_d = vld_p1_q;
        if (s1_free) begin
            vld_p1_d = in_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            key_a_p1_q <= order_key(a);
            key_b_p1_q <= order_key(b);
            a_p1_q     <= a;
            b_p1_q     <= b;
            mode_p1_q  <= mode;
`ifdef FLOAT_CMP_NAN_EN
            nan_a_p1_q <= is_nan(a);
            nan_b_p1_q <= is_nan(b);
`endif
        end
    end

    // ---- Stage 2: compare keys, select flag and larger operand ----
    always_comb begin
        cmp_unord  = 1'b0;
        cmp_result = mode_select(mode_p1_q,
                                 key_a_p1_q > key_b_p1_q,
                                 key_a_p1_q < key_b_p1_q,
                                 key_a_p1_q == key_b_p1_q);
        cmp_max    = (key_b_p1_q > key_a_p1_q) ? b_p1_q : a_p1_q;
`ifdef FLOAT_CMP_NAN_EN
        cmp_unord = nan_a_p1_q || nan_b_p1_q;
        if (cmp_unord) begin
            cmp_result = 1'b0;
            cmp_max    = (nan_a_p1_q && !nan_b_p1_q) ? b_p1_q : a_p1_q;
        end
`endif
    end

    always_comb begin
        vld_p2_d    = vld_p2_q;
        result_p2_d = result_p2_q;
        max_p2_d    = max_p2_q;
`ifdef FLOAT_CMP_NAN_EN
        unord_p2_d  = unord_p2_q;
`endif
        if (s2_free) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                result_p2_d = cmp_result;
                max_p2_d    = cmp_max;
`ifdef FLOAT_CMP_NAN_EN
                unord_p2_d  = cmp_unord;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2_q    <= 1'b0;
            result_p2_q <= 1'b0;
            max_p2_q    <= '0;
`ifdef FLOAT_CMP_NAN_EN
            unord_p2_q  <= 1'b0;
`endif
        end else begin
            vld_p2_q    <= vld_p2_d;
            result_p2_q <= result_p2_d;
            max_p2_q    <= max_p2_d;
`ifdef FLOAT_CMP_NAN_EN
            unord_p2_q  <= unord_p2_d;
`endif
        end
    end

    // ---- Running maximum: clear takes effect before a coincident handshake ----
    always_comb begin
        max_ok = 1'b1;
`ifdef FLOAT_CMP_NAN_EN
        max_ok = !is_nan(max_p2_q);
`endif
        base_vld  = run_vld_q && !clr;
        base_max  = clr ? '0 : run_max_q;
        run_vld_d = base_vld;
        run_max_d = base_max;
        if (out_fire && max_ok &&
            (!base_vld || (order_key(max_p2_q) > order_key(base_max)))) begin
            run_vld_d = 1'b1;
            run_max_d = max_p2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_max_q <= '0;
            run_vld_q <= 1'b0;
        end else begin
            run_max_q <= run_max_d;
            run_vld_q <= run_vld_d;
        end
    end

    assign out_valid     = vld_p2_q;
    assign result        = result_p2_q;
    assign max_out       = max_p2_q;
    assign run_max       = run_max_q;
    assign run_max_valid = run_vld_q;
`ifdef FLOAT_CMP_NAN_EN
    assign unordered     = unord_p2_q;
`endif

endmodule

// File: tb/tb_float_cmp_stream.sv
// Scoreboard bench for float_cmp_stream at default widths (13-bit operands).
// Honours FLOAT_CMP_NAN_EN for the unordered port and NaN steps.
module tb_float_cmp_stream;

    localparam int W = 13;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a, b;
    logic [1:0]     mode;
    logic           out_valid;
    logic           out_ready;
    logic           result;
    logic [W-1:0]   max_out;
    logic           clr;
    logic [W-1:0]   run_max;
    logic           run_max_valid;
`ifdef FLOAT_CMP_NAN_EN
    logic           unordered;
`endif

    always #5 clk = ~clk;

    float_cmp_stream dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .a             (a),
        .b             (b),
        .mode          (mode),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .max_out       (max_out),
`ifdef FLOAT_CMP_NAN_EN
        .unordered     (unordered),
`endif
        .clr           (clr),
        .run_max       (run_max),
        .run_max_valid (run_max_valid)
    );

    typedef struct packed {
        logic           res;
        logic           unord;
        logic [W-1:0]   mx;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic nan_of(input logic [W-1:0] x);
`ifdef FLOAT_CMP_NAN_EN
        return (x[11:8] == 4'hF) && (x[7:0] != 8'h00);
`else
        return 1'b0;
`endif
    endfunction

    // Sign-magnitude reference: returns 0 equal, 1 a>b, 2 a<b.
    function automatic int rel_of(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [11:0] mx, my;
        logic        sx, sy;
        mx = x[11:0];
        my = y[11:0];
        sx = x[12] && (mx != 0);
        sy = y[12] && (my != 0);
        if (sx == sy && mx == my) return 0;
        if (sx != sy)             return sx ? 2 : 1;
        if (!sx)                  return (mx > my) ? 1 : 2;
        return (mx > my) ? 2 : 1;
    endfunction

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [1:0] m);
        exp_t e;
        int   r;
        r = rel_of(x, y);
        case (m)
            2'b00:   e.res = (r == 1);
            2'b01:   e.res = (r == 2);
            2'b10:   e.res = (r == 0);
            default: e.res = (r != 2);
        endcase
        e.mx    = (r == 2) ? y : x;
        e.unord = nan_of(x) || nan_of(y);
        if (e.unord) begin
            e.res = 1'b0;
            e.mx  = (nan_of(x) && !nan_of(y)) ? y : x;
        end
        return e;
    endfunction

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [1:0] m);
        int n;
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        mode     = m;
        n        = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        checks++;
        assert (in_ready) else begin
            failures++;
            $error("FAIL send_timeout observed in_ready=%0b expected=1", in_ready);
        end
        if (in_ready) sb_q.push_back(model(av, bv, m));
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        chk("drain_pending", sb_q.size(), 0);
    endtask

    logic         prev_stall = 1'b0;
    logic         prev_res;
    logic [W-1:0] prev_max;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && prev_stall) begin
            chk("stall_result", result, prev_res);
            chk("stall_max", max_out, prev_max);
        end
        if (rst_n && out_valid && out_ready) begin
            checks++;
            assert (sb_q.size() > 0) else begin
                failures++;
                $error("FAIL extra_output observed max_out=0x%0h expected=no output", max_out);
            end
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("result", result, e.res);
                chk("max_out", max_out, e.mx);
`ifdef FLOAT_CMP_NAN_EN
                chk("unordered", unordered, e.unord);
`endif
            end
        end
        prev_stall = rst_n && out_valid && !out_ready;
        prev_res   = result;
        prev_max   = max_out;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        mode      = 2'b00;
        out_ready = 1'b1;
        clr       = 1'b0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_max_out", max_out, 0);
        chk("rst_run_max", run_max, 0);
        chk("rst_run_max_valid", run_max_valid, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        chk("rst_in_ready", in_ready, 1);

        // Basic compare with exact two-cycle latency
        send(13'h0380, 13'h0280, 2'b00);
        chk("lat_cycle1_out_valid", out_valid, 0);
        @(posedge clk); #2;
        chk("lat_cycle2_out_valid", out_valid, 1);
        drain();

        // Negatives and signed zero
        send(13'h1380, 13'h1280, 2'b01);
        send(13'h1380, 13'h1280, 2'b11);
        send(13'h1000, 13'h0000, 2'b10);
        send(13'h1000, 13'h0000, 2'b00);
        drain();

        // Backpressure: four pairs with output stalled for five cycles
        out_ready = 1'b0;
        fork
            begin
                send(13'h0100, 13'h0200, 2'b00);
                send(13'h1100, 13'h0050, 2'b11);
                chk("bp_in_ready_low", in_ready, 0);
                send(13'h0777, 13'h0777, 2'b10);
                send(13'h1FFF, 13'h0001, 2'b01);
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Running max: clear alone, accumulate, then clear coincident with a handshake
        clr = 1'b1;
        @(posedge clk); #2;
        clr = 1'b0;
        chk("clr_run_max", run_max, 0);
        chk("clr_run_max_valid", run_max_valid, 0);
        send(13'h0280, 13'h0100, 2'b00);
        repeat (3) @(posedge clk); #2;
        chk("rm1", run_max, 13'h0280);
        send(13'h0100, 13'h0380, 2'b00);
        repeat (3) @(posedge clk); #2;
        chk("rm2", run_max, 13'h0380);
        send(13'h1500, 13'h1600, 2'b00);
        repeat (3) @(posedge clk); #2;
        chk("rm3", run_max, 13'h0380);
        send(13'h0100, 13'h0000, 2'b00);
        @(posedge clk); #2;
        chk("rm_clr_pending_valid", out_valid, 1);
        clr = 1'b1;
        @(posedge clk); #2;
        clr = 1'b0;
        chk("rm4", run_max, 13'h0100);
        chk("rm4_valid", run_max_valid, 1);

`ifdef FLOAT_CMP_NAN_EN
        send(13'h0380, 13'h0100, 2'b00);
        drain();
        for (int m = 0; m < 4; m++) send(13'h0F01, 13'h0100, m[1:0]);
        drain();
        chk("nan_run_max", run_max, 13'h0380);
`endif

        // Randomised stream with random backpressure
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    logic [W-1:0] ra, rb;
                    ra = W'($urandom_range(0, 8191));
                    case ($urandom_range(0, 3))
                        0:       rb = ra;
                        1:       rb = {~ra[12], ra[11:0]};
                        default: rb = W'($urandom_range(0, 8191));
                    endcase
                    if (i % 7 == 3) begin
                        ra = 13'h1000;
                        rb = 13'h0000;
                    end
                    send(ra, rb, 2'($urandom_range(0, 3)));
                end
            end
            begin
                repeat (60) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset mid-stream discards the in-flight pair
        send(13'h0444, 13'h0333, 2'b00);
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_run_max_valid", run_max_valid, 0);
        chk("midrst_run_max", run_max, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            chk("post_rst_no_output", out_valid, 0);
        end
        chk("post_rst_in_ready", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
